keys_debounce_sched: RTL and testbench
======================================

// Module: keys_debounce_sched
// PURPOSE
//  Round-robin debounce scheduler between the raw key inputs and the SPI key-readout slave.
//  - One shared debounce evaluator and a per-key counter bank, time-multiplexed over NUM_KEYS keys.
//  - Holds the debounced key vector.
//  - Hands a frozen snapshot to the SPI slave on request, so one SPI frame always sees a coherent vector.
// PARAMETERS
//  NUM_KEYS        89  number of key inputs
//  TICK_DIV        16  clocks per scan slot; one key is evaluated per slot; >=2
//  DEBOUNCE_TICKS  8   consecutive disagreeing evaluations needed to flip a key; 1..2**CNT_W-1
//  CNT_W           4   width of each per-key debounce counter
// PORTS
//  clk_g_i        in   1         system clock
//  rst_g_i        in   1         asynchronous reset, active-high
//  en_i           in   1         scan enable; low freezes prescaler, index and counters
//  keys_i_g       in   NUM_KEYS  raw asynchronous key levels, 1 = pressed
//  snap_req_i     in   1         snapshot request, single-cycle pulse, already in clk_g_i domain
//  snap_ack_o     out  1         one-cycle pulse; keys_snap_o valid and frozen from this cycle
//  keys_snap_o    out  NUM_KEYS  snapshot of keys_stable_o, held until the next request
//  keys_stable_o  out  NUM_KEYS  debounced key vector
//  changed_o      out  1         sticky: some stable bit flipped since the last snapshot
//  scan_idx_o     out  IDX_W     key currently being evaluated; IDX_W = clog2(NUM_KEYS)
//  scan_wrap_o    out  1         one-cycle pulse when key NUM_KEYS-1 is evaluated
// BEHAVIOUR
//  Reset values: all outputs 0, counters 0, prescaler 0, state S_WAIT.
//  Input path: keys_i_g passes through a 2-flop synchroniser; evaluation reads only the synchronised bit.
//  FSM states:
//  - S_WAIT: prescaler counts 0..TICK_DIV-2. On reaching TICK_DIV-2 with en_i=1, go to S_EVAL.
//  - S_EVAL: one cycle; evaluate key scan_idx_o, then go to S_WAIT.
//    - Index increments and wraps from NUM_KEYS-1 to 0.
//    - scan_wrap_o pulses in the S_EVAL cycle of key NUM_KEYS-1.
//  - en_i=0: hold state, prescaler, index and counters. An S_EVAL cycle with en_i=0 is deferred, not skipped.
//  - Slot period is exactly TICK_DIV clocks. Sweep period is NUM_KEYS*TICK_DIV clocks.
//  Evaluation of key k:
//  - sync[k]==stable[k]: cnt[k] <= 0.
//  - Otherwise, if cnt[k]==DEBOUNCE_TICKS-1: stable[k] flips, cnt[k] <= 0, changed_o <= 1.
//  - Otherwise: cnt[k] <= cnt[k]+1. No counter wrap is possible.
//  - A glitch shorter than DEBOUNCE_TICKS consecutive evaluations never reaches keys_stable_o.
//  - Flip latency after an input settles: DEBOUNCE_TICKS sweeps max, plus 2 synchroniser cycles.
//  Snapshot on snap_req_i:
//  - Next cycle: keys_snap_o <= keys_stable_o as registered in the request cycle.
//  - snap_ack_o pulses in that same next cycle; changed_o clears in that cycle.
//  Simultaneous events:
//  - A flip in the request cycle is excluded from the snapshot. changed_o is 1 after the ack
//    (the set wins over the clear), so the flip is reported in the next frame.
//  - Back-to-back requests: each gets its own ack, one cycle later.
//  Reset mid-operation: immediate return to reset values. Snapshot contents and any pending ack are discarded.
// STRUCTURE
//  keys_pkg.vh holds:
//  - IDX_W and the clog2 helper
//  - state encodings S_WAIT=1'b0, S_EVAL=1'b1
//  - default NUM_KEYS
//  Sub-module keys_sync2: parameterised-width 2-flop synchroniser with asynchronous active-high reset.
//  Counter bank: a flat NUM_KEYS*CNT_W register, indexed by scan_idx_o. One read-modify-write per slot.
// TESTING (bench params: NUM_KEYS=4, TICK_DIV=2, DEBOUNCE_TICKS=3; sweep = 8 clocks)
//  1 Reset released, keys=0: scan_idx_o cycles 0,1,2,3 with one index per 2 clocks;
//    scan_wrap_o every 8 clocks; all outputs 0.
//  2 keys_i_g=4'b0100 held: keys_stable_o becomes 4'b0100 within 3 sweeps + 2 clocks (<=26);
//    changed_o=1.
//  3 Key1 high for exactly 2 evaluations, then low: keys_stable_o stays 4'b0000; cnt[1] returns to 0.
//  4 Stable=4'b0100, snap_req_i pulse: snap_ack_o next cycle; keys_snap_o=4'b0100; changed_o=0.
//  5 snap_req_i in the same cycle key3 flips: keys_snap_o excludes bit 3; changed_o=1 after the ack;
//    the next snapshot includes bit 3.
//  6 en_i=0 for 20 clocks during a debounce: scan_idx_o and counters frozen; the flip completes
//    after re-enable. rst_g_i pulse mid-scan: all outputs 0 the same cycle.

Source files
------------

// File: rtl/keys_debounce_sched_pkg.sv
// Shared types and helpers for the key debounce scheduler.
package keys_debounce_sched_pkg;

    localparam int unsigned NUM_KEYS_DEF = 89;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_EVAL = 1'b1
    } state_t;

    // Ceiling log2, never below 1 so that every derived vector has at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned IDX_W_DEF = clog2_min1(NUM_KEYS_DEF);

endpackage

// File: rtl/keys_debounce_sched_sync2.sv
// Two-flop synchroniser bringing the raw key levels into the system clock domain.
module keys_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keys_debounce_sched.sv
// Round-robin debounce scheduler: one shared evaluator walks a per-key counter bank and
// freezes a coherent snapshot of the debounced vector for the SPI readout on request.
module keys_debounce_sched
    import keys_debounce_sched_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = NUM_KEYS_DEF,
    parameter int unsigned TICK_DIV       = 16,
    parameter int unsigned DEBOUNCE_TICKS = 8,
    parameter int unsigned CNT_W          = 4,
    localparam int unsigned IDX_W         = clog2_min1(NUM_KEYS)
) (
    input  logic                clk_g_i,
    input  logic                rst_g_i,
    input  logic                en_i,
    input  logic [NUM_KEYS-1:0] keys_i_g,
    input  logic                snap_req_i,
    output logic                snap_ack_o,
    output logic [NUM_KEYS-1:0] keys_snap_o,
    output logic [NUM_KEYS-1:0] keys_stable_o,
    output logic                changed_o,
    output logic [IDX_W-1:0]    scan_idx_o,
    output logic                scan_wrap_o
);

    localparam int unsigned PRESC_W = clog2_min1(TICK_DIV);
    localparam int unsigned FLAT_W  = clog2_min1(NUM_KEYS * CNT_W);

    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 2);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0]   CNT_TOP   = CNT_W'(DEBOUNCE_TICKS - 1);

    state_t                      state_q;
    state_t                      state_d;
    logic [PRESC_W-1:0]          presc_q;
    logic [PRESC_W-1:0]          presc_d;
    logic [IDX_W-1:0]            idx_d;
    logic                        wrap_d;
    logic                        do_eval;
    logic                        flip;
    logic [NUM_KEYS-1:0]         keys_sync;
    logic [NUM_KEYS*CNT_W-1:0]   cnt_q;
    logic [FLAT_W-1:0]           cnt_base;
    logic [CNT_W-1:0]            cnt_cur;
    logic [CNT_W-1:0]            cnt_nxt;

    keys_sync2 #(
        .W (NUM_KEYS)
    ) u_sync (
        .clk (clk_g_i),
        .rst (rst_g_i),
        .d   (keys_i_g),
        .q   (keys_sync)
    );

    // State register and scan position.
    always_ff @(posedge clk_g_i or posedge rst_g_i) begin
        if (rst_g_i) begin
            state_q     <= S_WAIT;
            presc_q     <= '0;
            scan_idx_o  <= '0;
            scan_wrap_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            scan_idx_o  <= idx_d;
            scan_wrap_o <= wrap_d;
        end
    end

    // Slot sequencing; a disabled cycle holds everything, so a pending S_EVAL is only deferred.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = scan_idx_o;
        do_eval = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                if (en_i) begin
                    if (presc_q == PRESC_TOP) begin
                        state_d = S_EVAL;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            S_EVAL: begin
                if (en_i) begin
                    do_eval = 1'b1;
                    state_d = S_WAIT;
                    idx_d   = (scan_idx_o == LAST_IDX) ? '0 : scan_idx_o + 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase
        // Registered one cycle early so the pulse lines up with the S_EVAL cycle of the last key.
        wrap_d = (state_d == S_EVAL) && (idx_d == LAST_IDX);
    end

    // Shared evaluator: read-modify-write of the counter for the key under scan.
    always_comb begin
        cnt_base = FLAT_W'(scan_idx_o) * FLAT_W'(CNT_W);
        cnt_cur  = cnt_q[cnt_base +: CNT_W];
        cnt_nxt  = cnt_cur;
        flip     = 1'b0;
        if (do_eval) begin
            if (keys_sync[scan_idx_o] == keys_stable_o[scan_idx_o]) begin
                cnt_nxt = '0;
            end else if (cnt_cur == CNT_TOP) begin
                cnt_nxt = '0;
                flip    = 1'b1;
            end else begin
                cnt_nxt = cnt_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_g_i or posedge rst_g_i) begin
        if (rst_g_i) begin
            cnt_q         <= '0;
            keys_stable_o <= '0;
        end else if (do_eval) begin
            cnt_q[cnt_base +: CNT_W] <= cnt_nxt;
            if (flip) begin
                keys_stable_o[scan_idx_o] <= ~keys_stable_o[scan_idx_o];
            end
        end
    end

    // Snapshot handshake; a flip coinciding with the request wins over the clear of changed_o.
    always_ff @(posedge clk_g_i or posedge rst_g_i) begin
        if (rst_g_i) begin
            keys_snap_o <= '0;
            snap_ack_o  <= 1'b0;
            changed_o   <= 1'b0;
        end else begin
            snap_ack_o <= snap_req_i;
            if (snap_req_i) begin
                keys_snap_o <= keys_stable_o;
            end
            if (flip) begin
                changed_o <= 1'b1;
            end else if (snap_req_i) begin
                changed_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keys_debounce_sched.sv
// Randomised scoreboard bench for keys_debounce_sched against a slot-arithmetic reference model.
module tb_keys_debounce_sched;

    localparam int unsigned NK = 4;
    localparam int unsigned TD = 2;
    localparam int unsigned DT = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en;
    logic [NK-1:0] keys;
    logic          req;
    logic          ack;
    logic [NK-1:0] snap;
    logic [NK-1:0] stable;
    logic          changed;
    logic [IW-1:0] idx;
    logic          wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NK-1:0] snap;
        logic          chg;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state: n counts enabled cycles since reset.
    logic [NK-1:0] m_stable;
    logic [NK-1:0] m_h1;
    logic [NK-1:0] m_h2;
    logic          m_changed;
    int            m_run[NK];
    int            m_n;

    keys_debounce_sched #(
        .NUM_KEYS       (NK),
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DT),
        .CNT_W          (CW)
    ) dut (
        .clk_g_i       (clk),
        .rst_g_i       (rst),
        .en_i          (en),
        .keys_i_g      (keys),
        .snap_req_i    (req),
        .snap_ack_o    (ack),
        .keys_snap_o   (snap),
        .keys_stable_o (stable),
        .changed_o     (changed),
        .scan_idx_o    (idx),
        .scan_wrap_o   (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable  = '0;
        m_h1      = '0;
        m_h2      = '0;
        m_changed = 1'b0;
        m_n       = 0;
        for (int i = 0; i < int'(NK); i++) m_run[i] = 0;
        sb_q.delete();
    endtask

    function automatic int m_key();
        return (m_n / int'(TD)) % int'(NK);
    endfunction

    function automatic logic m_wrap();
        return (m_n % int'(TD) == int'(TD) - 1) && (m_key() == int'(NK) - 1);
    endfunction

    // Model: every TD-th enabled cycle evaluates key (n/TD) mod NK using the input from 2 cycles ago.
    initial begin
        logic [NK-1:0] old_stable;
        logic          m_flip;
        int            k;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                old_stable = m_stable;
                m_flip     = 1'b0;
                if (en) begin
                    if (m_n % int'(TD) == int'(TD) - 1) begin
                        k = m_key();
                        if (m_h2[k] != m_stable[k]) begin
                            m_run[k]++;
                            if (m_run[k] == int'(DT)) begin
                                m_stable[k] = ~m_stable[k];
                                m_run[k]    = 0;
                                m_flip      = 1'b1;
                            end
                        end else begin
                            m_run[k] = 0;
                        end
                    end
                    m_n++;
                end
                if (req) sb_q.push_back('{old_stable, m_flip});
                if (m_flip) m_changed = 1'b1;
                else if (req) m_changed = 1'b0;
                m_h2 = m_h1;
                m_h1 = keys;
            end
        end
    end

    // Monitor: acks drain the scoreboard; continuous state is compared against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("ack", 32'(ack), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (ack) begin
                    check("snap", 32'(snap), 32'(e.snap));
                    check("changed_after_ack", 32'(changed), 32'(e.chg));
                end
            end
            check("stable", 32'(stable), 32'(m_stable));
            check("changed", 32'(changed), 32'(m_changed));
            check("scan_idx", 32'(idx), 32'(m_key()));
            check("scan_wrap", 32'(wrap), 32'(m_wrap()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    initial begin
        int           waited;
        logic [IW-1:0] idx_saved;
        logic         hit;
        en   = 1'b1;
        keys = '0;
        req  = 1'b0;
        step(2);
        rst = 1'b0;

        // Idle sweep with all keys released.
        step(24);
        check("idle_stable", 32'(stable), 32'h0);

        // Key 2 held: must settle within three sweeps plus synchroniser delay.
        keys   = 4'b0100;
        waited = 0;
        while (stable !== 4'b0100 && waited < 27) begin
            step();
            waited++;
        end
        check("press_latency", 32'(stable), 32'h4);
        check("press_changed", 32'(changed), 32'h1);

        pulse_req();
        check("snap_direct", 32'(snap), 32'h4);
        check("snap_clears_changed", 32'(changed), 32'h0);

        // Short glitch on key 1 (at most two evaluations) must not reach the stable vector.
        keys[1] = 1'b1;
        step(10);
        keys[1] = 1'b0;
        step(30);
        check("glitch_rejected", 32'(stable), 32'h4);

        // Request in the exact cycle key 3 flips.
        keys[3] = 1'b1;
        hit     = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (m_n % int'(TD) == int'(TD) - 1 && m_key() == 3 &&
                m_h2[3] != m_stable[3] && m_run[3] == int'(DT) - 1) begin
                hit = 1'b1;
                pulse_req();
                check("coincident_snap_excludes", 32'(snap[3]), 32'h0);
                check("coincident_changed_set", 32'(changed), 32'h1);
                pulse_req();
                check("next_snap_includes", 32'(snap), 32'hC);
            end else begin
                step();
            end
        end
        check("coincident_reached", 32'(hit), 32'h1);

        // Disable during a debounce of key 2 back to 0.
        keys[2] = 1'b0;
        step(5);
        en        = 1'b0;
        idx_saved = idx;
        step(20);
        check("idx_frozen", 32'(idx), 32'(idx_saved));
        check("stable_frozen", 32'(stable), 32'hC);
        en     = 1'b1;
        waited = 0;
        while (stable !== 4'b1000 && waited < 40) begin
            step();
            waited++;
        end
        check("release_after_enable", 32'(stable), 32'h8);

        // Asynchronous reset mid-scan.
        step(3);
        rst = 1'b1;
        #1;
        check("reset_outputs", {25'(0), ack, changed, wrap, idx, (|snap) | (|stable)}, 32'h0);
        step();
        rst = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
            en  = ($urandom_range(0, 7) != 0);
            req = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 599) == 0) begin
                req = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        req = 1'b0;
        en  = 1'b1;
        step(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
